// File: rtl/afu_pkg.sv
// Shared definitions for the transpose AFU output path.
// Holds the writer FSM state encoding and default widths used by the
// output writer and its line skid FIFO.
package afu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } wr_state_e;

   localparam int LINE_BYTES     = 64;
   localparam int AFU_DATA_WIDTH = 512;
   localparam int AFU_ADDR_WIDTH = 32;
   localparam int AFU_LEN_WIDTH  = 32;
   localparam int SKID_DEPTH     = 3;

endpackage

// File: rtl/line_skid_fifo.sv
// Three-entry line buffer between the output-FIFO read port and the host
// write port. Absorbs the one-cycle read latency plus write back-pressure.
// Ports:
//   clk, reset_n     clock, async active-low reset (clears contents too)
//   push_i, data_i   write one line (ignored when full)
//   pop_i            drop the head line (ignored when empty)
//   data_o           head line
//   count_o          number of lines held (0..3)
//   empty_o          no lines held
module line_skid_fifo
   import afu_pkg::*;
#(
   parameter int DATA_WIDTH = AFU_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic [1:0]            count_o,
   output logic                  empty_o
);

   logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
   logic [1:0]            wr_ptr_q;
   logic [1:0]            rd_ptr_q;
   logic [1:0]            count_q;
   logic                  do_push;
   logic                  do_pop;

   function automatic logic [1:0] next_ptr(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   assign empty_o = (count_q == 2'd0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];
   assign do_push = push_i & (count_q != 2'd3);
   assign do_pop  = pop_i & ~empty_o;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= 2'd0;
         rd_ptr_q <= 2'd0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= next_ptr(wr_ptr_q);
         end
         if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/afu_output_writer.sv
// Drains the AFU output FIFO and issues one host write per line, at line
// address base_addr + line index, finishing after ctx_length lines.
//
// state | meaning
// IDLE  | waiting for start; job registers hold last job's results
// RUN   | reading FIFO lines and issuing writes
// DONE  | one-cycle completion pulse, then back to IDLE
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   start, base_addr, ctx_length job launch (accepted only in IDLE)
//   fifo_dout, fifo_empty        output FIFO data (1-cycle latency) / empty
//   fifo_re                      output FIFO read enable
//   wr_valid, wr_ready           write request handshake
//   wr_addr, wr_data             write line address / data
//   busy, done, lines_written    status
module afu_output_writer
   import afu_pkg::*;
#(
   parameter int DATA_WIDTH = AFU_DATA_WIDTH,
   parameter int ADDR_WIDTH = AFU_ADDR_WIDTH,
   parameter int LEN_WIDTH  = AFU_LEN_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]  ctx_length,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   input  logic                  fifo_empty,
   output logic                  fifo_re,
   output logic                  wr_valid,
   input  logic                  wr_ready,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  busy,
   output logic                  done,
   output logic [LEN_WIDTH-1:0]  lines_written
);

   wr_state_e             state_q;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [LEN_WIDTH-1:0]  reads_issued_q;
   logic [LEN_WIDTH-1:0]  lines_written_q;
   logic                  inflight_q;

   logic [1:0]            skid_count;
   logic                  skid_empty;
   logic [2:0]            occ;
   logic                  wr_fire;
   logic                  last_write;

   // Occupancy counts the read already in flight so the skid can never
   // be over-committed; it depends only on registers, keeping wr_ready
   // off the fifo_re path.
   assign occ        = {1'b0, skid_count} + {2'b00, inflight_q};
   assign fifo_re    = (state_q == ST_RUN) & ~fifo_empty &
                       (reads_issued_q < len_q) & (occ < 3'd3);
   assign wr_valid   = ~skid_empty;
   assign wr_fire    = wr_valid & wr_ready;
   assign last_write = wr_fire & (lines_written_q == len_q - LEN_WIDTH'(1));
   assign wr_addr    = base_q + ADDR_WIDTH'(lines_written_q);
   assign busy          = (state_q != ST_IDLE);
   assign done          = (state_q == ST_DONE);
   assign lines_written = lines_written_q;

   line_skid_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (inflight_q),
      .data_i  (fifo_dout),
      .pop_i   (wr_fire),
      .data_o  (wr_data),
      .count_o (skid_count),
      .empty_o (skid_empty)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= ST_IDLE;
         base_q          <= '0;
         len_q           <= '0;
         reads_issued_q  <= '0;
         lines_written_q <= '0;
         inflight_q      <= 1'b0;
      end else begin
         inflight_q <= fifo_re;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  base_q          <= base_addr;
                  len_q           <= ctx_length;
                  reads_issued_q  <= '0;
                  lines_written_q <= '0;
                  state_q         <= (ctx_length == '0) ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               if (fifo_re) reads_issued_q  <= reads_issued_q + LEN_WIDTH'(1);
               if (wr_fire) lines_written_q <= lines_written_q + LEN_WIDTH'(1);
               if (last_write) state_q <= ST_DONE;
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_afu_output_writer.sv
module tb_afu_output_writer;

   localparam int DW = 512;
   localparam int AW = 32;
   localparam int LW = 32;

   logic          clk;
   logic          reset_n;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [LW-1:0] ctx_length;
   logic [DW-1:0] fifo_dout;
   logic          fifo_empty;
   logic          fifo_re;
   logic          wr_valid;
   logic          wr_ready;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          busy;
   logic          done;
   logic [LW-1:0] lines_written;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   // source FIFO model: tasks write src_mem/src_wr, the model owns src_rd
   logic [DW-1:0] src_mem [128];
   int src_wr = 0;
   int src_rd = 0;

   // write capture and event counters, owned by the monitor
   logic [AW-1:0] cap_addr [128];
   logic [DW-1:0] cap_data [128];
   int            cap_cyc  [128];
   int cap_n = 0;
   int re_cnt = 0;
   int wv_cnt = 0;
   int done_cnt = 0;

   afu_output_writer dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .base_addr     (base_addr),
      .ctx_length    (ctx_length),
      .fifo_dout     (fifo_dout),
      .fifo_empty    (fifo_empty),
      .fifo_re       (fifo_re),
      .wr_valid      (wr_valid),
      .wr_ready      (wr_ready),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .busy          (busy),
      .done          (done),
      .lines_written (lines_written)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign fifo_empty = (src_rd == src_wr);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_re && (src_rd != src_wr)) begin
         fifo_dout <= src_mem[src_rd % 128];
         src_rd    <= src_rd + 1;
      end
      if (reset_n && wr_valid && wr_ready) begin
         cap_addr[cap_n] <= wr_addr;
         cap_data[cap_n] <= wr_data;
         cap_cyc[cap_n]  <= cyc;
         cap_n           <= cap_n + 1;
      end
      if (fifo_re)  re_cnt   <= re_cnt + 1;
      if (wr_valid) wv_cnt   <= wv_cnt + 1;
      if (done)     done_cnt <= done_cnt + 1;
   end

   function automatic logic [DW-1:0] mkdata(input int tag, input int idx);
      logic [DW-1:0] d;
      logic [31:0]   w;
      w = 32'(tag) * 32'h0001_0000 + 32'(idx);
      for (int l = 0; l < 16; l++) d[l*32 +: 32] = w + 32'(l) * 32'h0100_0000;
      return d;
   endfunction

   task automatic load(input int tag, input int first, input int n);
      for (int i = 0; i < n; i++) begin
         src_mem[src_wr % 128] = mkdata(tag, first + i);
         src_wr = src_wr + 1;
      end
   endtask

   task automatic flush_src();
      src_wr = src_rd;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; start = 1'b0; wr_ready = 1'b1;
      base_addr = '0; ctx_length = '0;
      repeat (3) @(negedge clk);
      flush_src();
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse_start(input logic [AW-1:0] b, input logic [LW-1:0] n, output int cs);
      @(negedge clk);
      start = 1'b1; base_addr = b; ctx_length = n; cs = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok, output int dcyc);
      ok = 1'b0; dcyc = -1;
      for (int i = 0; i < budget; i++) begin
         if (done) begin ok = 1'b1; dcyc = cyc; break; end
         @(negedge clk);
      end
   endtask

   task automatic wait_lw(input int k, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (lines_written == LW'(k)) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; wr_ready = 1'b1;
      base_addr = '0; ctx_length = '0;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
      n_cmp++; if (fifo_re !== 1'b0) begin n_err++; $display("FAIL rst_fifo_re: got %b want 0", fifo_re); end
      n_cmp++; if (wr_valid !== 1'b0) begin n_err++; $display("FAIL rst_wr_valid: got %b want 0", wr_valid); end
      n_cmp++; if (lines_written !== '0) begin n_err++; $display("FAIL rst_lines: got %0d want 0", lines_written); end
      n_cmp++; if (wr_addr !== '0) begin n_err++; $display("FAIL rst_wr_addr: got %h want 0", wr_addr); end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int cs, dcyc, c0; bit ok;
      do_reset();
      load(1, 0, 4);
      c0 = cap_n;
      pulse_start(32'h100, 4, cs);
      wait_done(60, ok, dcyc);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL t1_done_timeout: got none want done"); end
      n_cmp++; if (cap_n - c0 !== 4) begin n_err++; $display("FAIL t1_count: got %0d want 4", cap_n - c0); end
      for (int i = 0; i < 4; i++) if (c0 + i < cap_n) begin
         n_cmp++; if (cap_addr[c0+i] !== 32'h100 + 32'(i)) begin n_err++; $display("FAIL t1_addr[%0d]: got %h want %h", i, cap_addr[c0+i], 32'h100 + 32'(i)); end
         n_cmp++; if (cap_data[c0+i] !== mkdata(1, i)) begin n_err++; $display("FAIL t1_data[%0d]: got %h want %h", i, cap_data[c0+i][31:0], mkdata(1, i) & 32'hffff_ffff); end
         n_cmp++; if (cap_cyc[c0+i] !== cs + 3 + i) begin n_err++; $display("FAIL t1_cycle[%0d]: got %0d want %0d", i, cap_cyc[c0+i], cs + 3 + i); end
      end
      n_cmp++; if (dcyc !== cs + 7) begin n_err++; $display("FAIL t1_done_cycle: got %0d want %0d", dcyc, cs + 7); end
      n_cmp++; if (lines_written !== 32'd4) begin n_err++; $display("FAIL t1_lines: got %0d want 4", lines_written); end
      @(negedge clk);
      n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL t1_after_done: got done=%b busy=%b want 0 0", done, busy); end
   endtask

   task automatic test_zero_len();
      int cs, r0, w0;
      do_reset();
      load(2, 0, 2);
      r0 = re_cnt; w0 = wv_cnt;
      pulse_start(32'h55, 0, cs);
      n_cmp++; if (done !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL t2_done_pulse: got done=%b busy=%b want 1 1", done, busy); end
      @(negedge clk);
      n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL t2_idle: got done=%b busy=%b want 0 0", done, busy); end
      repeat (3) @(negedge clk);
      n_cmp++; if (re_cnt !== r0) begin n_err++; $display("FAIL t2_fifo_re: got %0d reads want 0", re_cnt - r0); end
      n_cmp++; if (wv_cnt !== w0) begin n_err++; $display("FAIL t2_wr_valid: got %0d valid cycles want 0", wv_cnt - w0); end
      n_cmp++; if (lines_written !== '0) begin n_err++; $display("FAIL t2_lines: got %0d want 0", lines_written); end
      flush_src();
   endtask

   task automatic test_backpressure();
      int cs, dcyc, c0; bit ok;
      do_reset();
      load(3, 0, 8);
      c0 = cap_n;
      pulse_start(32'h200, 8, cs);
      wait_lw(2, 60, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL t3_reach_line2: got timeout want lines_written=2"); end
      wr_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         n_cmp++; if (wr_valid !== 1'b1 || wr_addr !== 32'h202 || wr_data !== mkdata(3, 2)) begin
            n_err++; $display("FAIL t3_stall[%0d]: got v=%b a=%h want v=1 a=00000202 (line 2 data)", k, wr_valid, wr_addr);
         end
         @(negedge clk);
      end
      n_cmp++; if (fifo_re !== 1'b0) begin n_err++; $display("FAIL t3_fifo_re_full: got %b want 0", fifo_re); end
      n_cmp++; if (lines_written !== 32'd2) begin n_err++; $display("FAIL t3_lines_stalled: got %0d want 2", lines_written); end
      wr_ready = 1'b1;
      wait_done(60, ok, dcyc);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL t3_done_timeout: got none want done"); end
      n_cmp++; if (cap_n - c0 !== 8) begin n_err++; $display("FAIL t3_count: got %0d want 8", cap_n - c0); end
      for (int i = 0; i < 8; i++) if (c0 + i < cap_n) begin
         n_cmp++; if (cap_addr[c0+i] !== 32'h200 + 32'(i) || cap_data[c0+i] !== mkdata(3, i)) begin
            n_err++; $display("FAIL t3_line[%0d]: got a=%h want %h", i, cap_addr[c0+i], 32'h200 + 32'(i));
         end
      end
      n_cmp++; if (lines_written !== 32'd8) begin n_err++; $display("FAIL t3_lines: got %0d want 8", lines_written); end
   endtask

   task automatic test_fifo_gap();
      int cs, dcyc, c0; bit ok;
      do_reset();
      load(4, 0, 3);
      c0 = cap_n;
      pulse_start(32'h300, 6, cs);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (cap_n - c0 == 3) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      n_cmp++; if (!ok) begin n_err++; $display("FAIL t4_first3_timeout: got %0d lines want 3", cap_n - c0); end
      for (int k = 0; k < 5; k++) begin
         n_cmp++; if (wr_valid !== 1'b0 || fifo_re !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL t4_gap[%0d]: got v=%b re=%b busy=%b want 0 0 1", k, wr_valid, fifo_re, busy);
         end
         @(negedge clk);
      end
      load(4, 3, 3);
      wait_done(60, ok, dcyc);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL t4_done_timeout: got none want done"); end
      n_cmp++; if (cap_n - c0 !== 6) begin n_err++; $display("FAIL t4_count: got %0d want 6", cap_n - c0); end
      for (int i = 0; i < 6; i++) if (c0 + i < cap_n) begin
         n_cmp++; if (cap_addr[c0+i] !== 32'h300 + 32'(i) || cap_data[c0+i] !== mkdata(4, i)) begin
            n_err++; $display("FAIL t4_line[%0d]: got a=%h want %h", i, cap_addr[c0+i], 32'h300 + 32'(i));
         end
      end
   endtask

   task automatic test_reset_midjob();
      int cs, dcyc, c0, dn0; bit ok;
      do_reset();
      dn0 = done_cnt;
      load(5, 0, 16);
      pulse_start(32'h400, 16, cs);
      wait_lw(5, 60, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL t5_reach_line5: got timeout want lines_written=5"); end
      reset_n = 1'b0;
      #1;
      n_cmp++; if (fifo_re !== 1'b0 || wr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         n_err++; $display("FAIL t5_ctrl_zero: got re=%b v=%b busy=%b done=%b want 0", fifo_re, wr_valid, busy, done);
      end
      n_cmp++; if (lines_written !== '0 || wr_addr !== '0 || wr_data !== '0) begin
         n_err++; $display("FAIL t5_data_zero: got lines=%0d a=%h want 0 0", lines_written, wr_addr);
      end
      @(negedge clk);
      flush_src();
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      n_cmp++; if (done_cnt !== dn0 || busy !== 1'b0) begin n_err++; $display("FAIL t5_no_done: got %0d pulses busy=%b want 0 0", done_cnt - dn0, busy); end
      load(6, 0, 3);
      c0 = cap_n;
      pulse_start(32'h500, 3, cs);
      wait_done(60, ok, dcyc);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL t5_restart_timeout: got none want done"); end
      n_cmp++; if (cap_n - c0 !== 3) begin n_err++; $display("FAIL t5_count: got %0d want 3", cap_n - c0); end
      for (int i = 0; i < 3; i++) if (c0 + i < cap_n) begin
         n_cmp++; if (cap_addr[c0+i] !== 32'h500 + 32'(i) || cap_data[c0+i] !== mkdata(6, i)) begin
            n_err++; $display("FAIL t5_line[%0d]: got a=%h want %h", i, cap_addr[c0+i], 32'h500 + 32'(i));
         end
      end
   endtask

   task automatic test_addr_wrap();
      int cs, cs2, dcyc, c0; bit ok;
      logic [AW-1:0] exp_a [4];
      exp_a[0] = 32'hFFFF_FFFE; exp_a[1] = 32'hFFFF_FFFF; exp_a[2] = 32'h0; exp_a[3] = 32'h1;
      do_reset();
      load(7, 0, 4);
      c0 = cap_n;
      pulse_start(32'hFFFF_FFFE, 4, cs);
      repeat (2) @(negedge clk);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL t6_busy: got %b want 1", busy); end
      pulse_start(32'h0000_0000, 1, cs2);
      wait_done(60, ok, dcyc);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL t6_done_timeout: got none want done"); end
      n_cmp++; if (dcyc !== cs + 7) begin n_err++; $display("FAIL t6_done_cycle: got %0d want %0d", dcyc, cs + 7); end
      n_cmp++; if (cap_n - c0 !== 4) begin n_err++; $display("FAIL t6_count: got %0d want 4", cap_n - c0); end
      for (int i = 0; i < 4; i++) if (c0 + i < cap_n) begin
         n_cmp++; if (cap_addr[c0+i] !== exp_a[i] || cap_data[c0+i] !== mkdata(7, i)) begin
            n_err++; $display("FAIL t6_line[%0d]: got a=%h want %h", i, cap_addr[c0+i], exp_a[i]);
         end
      end
      n_cmp++; if (lines_written !== 32'd4) begin n_err++; $display("FAIL t6_lines: got %0d want 4", lines_written); end
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; wr_ready = 1'b1;
      base_addr = '0; ctx_length = '0;
      fifo_dout = '0;
      test_reset();
      test_basic();
      test_zero_len();
      test_backpressure();
      test_fifo_gap();
      test_reset_midjob();
      test_addr_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion want finish within 200000ns");
      $fatal(1, "watchdog expired");
   end

endmodule
